// File: rtl/key_input_ctrl.sv
// Push-button front end: per-button sync/debounce/press pulse, plus operand capture with valid/ready.
// Optional KEY_AUTO_REPEAT_EN adds hold-to-repeat on UP and DOWN.

module key_lane #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_s1, r_s2, r_stb, r_stb_d;
  logic [CW-1:0] r_cnt;
  logic          w_rep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_stb   <= 1'b0;
      r_stb_d <= 1'b0;
      r_cnt   <= '0;
      o_pulse <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_stb_d <= r_stb;
      if (r_s2 == r_stb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stb <= ~r_stb;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      o_pulse <= (r_stb & ~r_stb_d) | w_rep;
    end
  end

  if (REPEAT_EN) begin : g_rep
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] r_hold;
    // After the first repeat the counter reloads so the next hit comes REPEAT_PERIOD later
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_hold <= '0;
      else if (!(r_stb & r_stb_d))            r_hold <= '0;
      else if (r_hold == RW'(REPEAT_DELAY-1)) r_hold <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
      else                                    r_hold <= r_hold + RW'(1);
    end
    assign w_rep = r_stb & r_stb_d & (r_hold == RW'(REPEAT_DELAY - 1));
  end else begin : g_norep
    assign w_rep = 1'b0;
  end
endmodule

module key_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int MAX_VAL         = 9,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn,
  input  logic [7:0] sw,
  input  logic       out_ready,
  output logic [4:0] key_pulse,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       range_err
);
  localparam logic [7:0] MAXV = 8'(MAX_VAL);

  for (genvar gi = 0; gi < 5; gi++) begin : g_lane
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit REP = (gi == 2) || (gi == 3);
`else
    localparam bit REP = 1'b0;
`endif
    key_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REP),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (btn[gi]),
      .o_pulse(key_pulse[gi])
    );
  end

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     r_state;
  logic [7:0] r_sw_s1, r_sw_s2, r_data;
  logic       r_rerr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_data  <= '0;
      r_rerr  <= 1'b0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_rerr  <= 1'b0;
      // CANCEL outranks capture; a legal capture outranks the ready handshake
      if (key_pulse[1]) begin
        r_state <= EMPTY;
      end else if (key_pulse[0]) begin
        if (r_sw_s2 <= MAXV) begin
          r_data  <= r_sw_s2;
          r_state <= FULL;
        end else begin
          r_rerr <= 1'b1;
        end
      end else if (r_state == FULL && out_ready) begin
        r_state <= EMPTY;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = (r_state == FULL);
  assign range_err  = r_rerr;
endmodule

// File: tb/tb_key_input_ctrl.sv
// Randomised + directed bench for key_input_ctrl against a run-length / event-age reference model.
module tb_key_input_ctrl;
  localparam int DC  = 4;
  localparam int MAX = 9;
  localparam int RD  = 10;
  localparam int RP  = 3;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit REPEN = 1'b1;
`else
  localparam bit REPEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic [7:0] sw = '0;
  logic       out_ready = 1'b0;
  logic [4:0] key_pulse;
  logic [7:0] data_out;
  logic       data_valid;
  logic       range_err;

  int n_tests = 0;
  int n_fail  = 0;

  key_input_ctrl #(
    .DEBOUNCE_CYCLES(DC), .MAX_VAL(MAX), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw), .out_ready(out_ready),
    .key_pulse(key_pulse), .data_out(data_out), .data_valid(data_valid), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted after DC consecutive sampled mismatches;
  // repeats are defined by the age (cycles) since the press pulse.
  logic [4:0] m_s1, m_s2, m_stb, m_stbd, m_pulse;
  int         m_run [5];
  int         m_age [5];
  logic [7:0] m_sw1, m_sw2, m_data;
  logic       m_valid, m_rerr;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_stb = '0; m_stbd = '0; m_pulse = '0;
        m_sw1 = '0; m_sw2 = '0; m_data = '0; m_valid = 1'b0; m_rerr = 1'b0;
        for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_age[i] = 0; end
      end else begin
        m_rerr = 1'b0;
        if (m_pulse[1]) m_valid = 1'b0;
        else if (m_pulse[0]) begin
          if (int'(m_sw2) <= MAX) begin m_data = m_sw2; m_valid = 1'b1; end
          else m_rerr = 1'b1;
        end else if (out_ready) m_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
          bit rise, held, rep;
          rise = m_stb[i] && !m_stbd[i];
          held = m_stb[i] && m_stbd[i];
          if (held) m_age[i] = m_age[i] + 1; else m_age[i] = 0;
          rep = REPEN && (i == 2 || i == 3) && held && m_age[i] >= RD && ((m_age[i] - RD) % RP == 0);
          m_pulse[i] = rise || rep;
        end
        m_stbd = m_stb;
        for (int i = 0; i < 5; i++) begin
          if (m_s2[i] != m_stb[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DC) begin m_stb[i] = ~m_stb[i]; m_run[i] = 0; end
          end else m_run[i] = 0;
        end
        m_s2 = m_s1; m_s1 = btn; m_sw2 = m_sw1; m_sw1 = sw;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_key_pulse", 32'(key_pulse), 32'(m_pulse));
      chk("model_data_valid", 32'(data_valid), 32'(m_valid));
      chk("model_data_out", 32'(data_out), 32'(m_data));
      chk("model_range_err", 32'(range_err), 32'(m_rerr));
    end
  end

  task automatic wait_pulse(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (key_pulse[i]) begin ok = 1'b1; break; end
    end
    chk($sformatf("pulse_seen_%0d", i), 32'(ok), 32'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #12;
    chk("reset_key_pulse", 32'(key_pulse), 32'd0);
    chk("reset_data_valid", 32'(data_valid), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_range_err", 32'(range_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    settle(3);

    // bounce 1,0,1 then hold: one pulse 6 cycles after the final rise
    btn[2] = 1'b1; @(negedge clk);
    btn[2] = 1'b0; @(negedge clk);
    btn[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bounce_k%0d", k), 32'(key_pulse[2]), 32'(k == 6));
    end
    btn[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("release_no_pulse", 32'(key_pulse[2]), 32'd0);
    end

    // legal capture, held, then drained by out_ready
    sw = 8'd7; btn[0] = 1'b1;
    wait_pulse(0);
    btn[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("cap_valid", 32'(data_valid), 32'd1);
      chk("cap_data", 32'(data_out), 32'd7);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    chk("drain_valid", 32'(data_valid), 32'd0);
    chk("drain_data_hold", 32'(data_out), 32'd7);
    settle(10);

    // out-of-range operand
    sw = 8'd12; btn[0] = 1'b1;
    wait_pulse(0);
    btn[0] = 1'b0;
    @(negedge clk);
    chk("rerr_pulse", 32'(range_err), 32'd1);
    chk("rerr_valid", 32'(data_valid), 32'd0);
    chk("rerr_data", 32'(data_out), 32'd7);
    @(negedge clk);
    chk("rerr_single", 32'(range_err), 32'd0);
    settle(10);

    // FULL with 3, overwrite with 5 alongside out_ready, then CANCEL
    sw = 8'd3; btn[0] = 1'b1;
    wait_pulse(0);
    btn[0] = 1'b0;
    @(negedge clk);
    chk("full3_data", 32'(data_out), 32'd3);
    settle(10);
    sw = 8'd5; btn[0] = 1'b1;
    wait_pulse(0);
    btn[0] = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("ovw_data", 32'(data_out), 32'd5);
    chk("ovw_valid", 32'(data_valid), 32'd1);
    settle(10);
    btn[1] = 1'b1;
    wait_pulse(1);
    btn[1] = 1'b0;
    @(negedge clk);
    chk("cancel_valid", 32'(data_valid), 32'd0);
    settle(10);

    // async reset while FULL and mid-debounce; held button re-debounced once
    sw = 8'd4; btn[0] = 1'b1;
    wait_pulse(0);
    btn[0] = 1'b0;
    settle(10);
    chk("pre_rst_valid", 32'(data_valid), 32'd1);
    btn[4] = 1'b1;
    settle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_key_pulse", 32'(key_pulse), 32'd0);
    chk("arst_data_valid", 32'(data_valid), 32'd0);
    chk("arst_data_out", 32'(data_out), 32'd0);
    chk("arst_range_err", 32'(range_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wait_pulse(4);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_single", 32'(key_pulse[4]), 32'd0);
    end
    btn[4] = 1'b0;
    settle(12);

    // hold DOWN: repeats only when the feature is built
    btn[3] = 1'b1;
    wait_pulse(3);
    for (int k = 1; k <= 25; k++) begin
      bit e;
      e = REPEN && (k == 10 || k == 13 || k == 16 || k == 19 || k == 22);
      @(negedge clk);
      chk($sformatf("repeat_k%0d", k), 32'(key_pulse[3]), 32'(e));
    end
    btn[3] = 1'b0;
    settle(12);

    // random traffic, checked cycle by cycle against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      sw = 8'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) == 0);
    end
    btn = '0; out_ready = 1'b0;
    settle(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/key_input_ctrl.md
# key_input_ctrl

User-input front end for the matrix calculator. It synchronises and debounces the five board push-buttons and turns each debounced press into a one-cycle command pulse. It also captures an 8-bit operand from the slide switches on CONFIRM and hands it to the main FSM through a valid/ready handshake. It feeds the main FSM, which drives the display controller, so it is the input end of the user interface.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: cycles a raw level must stay stable before it is accepted (20 ms at 100 MHz).
- `MAX_VAL`, default 9: largest operand accepted from `sw`.
- `REPEAT_DELAY`, default 50_000_000: hold time before auto-repeat starts. Used only with `KEY_AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, default 20_000_000: interval between auto-repeat pulses. Used only with `KEY_AUTO_REPEAT_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn`  in  5  raw buttons, asynchronous to `clk`: [0] CONFIRM, [1] CANCEL, [2] UP, [3] DOWN, [4] MODE.
- `sw`  in  8  raw switches, unsigned operand.
- `out_ready`  in  1  FSM accepts `data_out` this cycle.
- `key_pulse`  out  5  one-cycle pulse per debounced press, same bit mapping as `btn`.
- `data_out`  out  8  captured operand, stable while `data_valid` is high.
- `data_valid`  out  1  operand pending.
- `range_err`  out  1  one-cycle pulse: CONFIRM pressed with `sw > MAX_VAL`.

## Operation
- Every flop resets asynchronously on `rst_n` low.
- Reset values: `key_pulse` 0, `data_out` 0, `data_valid` 0, `range_err` 0, all debounced states 0, all counters 0.
- Per button, the same logic applies independently:
  - 2-FF synchroniser, followed by a debounced state `stb` and a counter `cnt`. The counter width holds `DEBOUNCE_CYCLES-1`.
  - While the synchronised level equals `stb`, `cnt` is 0.
  - While it differs, `cnt` increments.
  - On a mismatch cycle with `cnt == DEBOUNCE_CYCLES-1`, `stb` toggles and `cnt` clears.
  - `key_pulse[i]` is registered. It is high for exactly the one cycle in which `stb` goes 0→1.
  - Release (1→0) produces no pulse.
  - A glitch shorter than `DEBOUNCE_CYCLES` produces no pulse.
- `sw` passes through its own 2-FF synchroniser. It is not debounced; its value is sampled at capture time.
- Capture FSM has two states, EMPTY (`data_valid` 0) and FULL (`data_valid` 1). The capture event is the cycle after `key_pulse[0]`.
  - Capture with synchronised `sw <= MAX_VAL`: `data_out` ← `sw`, go to FULL.
  - Capture with `sw > MAX_VAL`: `range_err` pulses for 1 cycle. State and `data_out` are unchanged.
  - FULL with `out_ready` high: go to EMPTY. `data_out` holds its value.
  - Capture while FULL with a legal value overwrites `data_out` and stays FULL. This also applies in the same cycle as `out_ready`: the new value wins.
  - The cycle after `key_pulse[1]` (CANCEL): go to EMPTY. CANCEL beats a simultaneous capture.
- `out_ready` while EMPTY is ignored.
- The other pulses (`key_pulse[2]` to `key_pulse[4]`) go to the FSM only.

## Timing
- Latency: `btn[i]` rises before clock edge 0 and stays stable. `key_pulse[i]` is high during the cycle after edge `DEBOUNCE_CYCLES+2`, and for exactly 1 cycle.
- `data_valid` rises, or `range_err` pulses, exactly 1 cycle after `key_pulse[0]`.
- `data_valid` falls 1 cycle after the edge that samples `out_ready`=1.
- Holding a button produces only one pulse, except as described in Configuration.
- Reset asserted mid-debounce or while FULL clears everything immediately. A button still held when `rst_n` deasserts is re-debounced and produces one pulse.

## Configuration
- `KEY_AUTO_REPEAT_EN` defined:
  - UP and DOWN (`btn[2]`, `btn[3]`) get a hold counter that starts at the press pulse.
  - After `REPEAT_DELAY` cycles of continuous `stb`=1, `key_pulse` fires again.
  - It then fires every `REPEAT_PERIOD` cycles until release.
  - The counter clears on release.
- Undefined: no repeat logic is built, and every button gives one pulse per press.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `MAX_VAL`=9, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Bounce and latency: `btn[2]` toggles 1,0,1 over 3 cycles, then holds high. Require exactly one `key_pulse[2]` at 6 cycles after the final rise, and no pulse on release.
- Legal capture: `sw`=7, CONFIRM pressed, `out_ready`=0. Require `data_valid`=1 and `data_out`=7, held for 20 cycles. Then `out_ready` goes high for 1 cycle; require `data_valid`=0 on the next cycle.
- Range error: `sw`=12, CONFIRM pressed. Require a single-cycle `range_err`, `data_valid` staying 0, and `data_out` unchanged.
- Overwrite and cancel: FULL with 3. CONFIRM with `sw`=5 in the same cycle as `out_ready` gives `data_out`=5 and FULL. Then CANCEL gives `data_valid`=0 on the following cycle.
- Reset mid-operation: `rst_n` is pulled low while FULL and while a debounce is in progress. Require all outputs 0 asynchronously.
- With `KEY_AUTO_REPEAT_EN`, hold DOWN for 25 cycles past the first pulse. Require pulses at +0, +10, +13, +16, +19, +22. Without the macro, require a single pulse.
